// File: rtl/memory_stage_pkg.sv
// Shared constants and the address-fault rule for the MEM pipeline stage.
// Defaults here feed the memory_stage parameters; the fault rule is opcode-independent.
package memory_stage_pkg;

  localparam int DM_DEPTH_DEF = 64;
  localparam int CNT_W_DEF    = 16;
  localparam int DM_IDX_W_DEF = $clog2(DM_DEPTH_DEF);

  function automatic int dm_idx_w(input int depth);
    return $clog2(depth);
  endfunction

  // Misaligned, or any byte-address bit above the word index is set.
  function automatic logic addr_fault(input logic [31:0] addr, input int idx_w);
    logic [31:0] upper;
    upper = addr >> (idx_w + 2);
    return (addr[1:0] != 2'b00) || (upper != 32'd0);
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// EX/MEM inputs, MEM/WB outputs and forwarding taps of the memory stage.
// The master side is the pipeline around the stage; the slave side is the stage itself.
interface memory_stage_if;

  logic        RFWEMdin;
  logic        MtoRFSelMdin;
  logic        DMWEMdin;
  logic [31:0] DMdinMdin;
  logic [31:0] ALUOutMdin;
  logic [4:0]  RFWAMdin;
  logic        StallM;
  logic        FlushM;

  logic        RFWEWdout;
  logic        MtoRFSelWdout;
  logic [31:0] DMoutWdout;
  logic [31:0] ALUOutWdout;
  logic [4:0]  RFWAWdout;

  logic        FwdRFWEM;
  logic [4:0]  FwdRFWAM;
  logic [31:0] FwdALUOutM;

  modport master (
    output RFWEMdin, MtoRFSelMdin, DMWEMdin, DMdinMdin, ALUOutMdin, RFWAMdin, StallM, FlushM,
    input  RFWEWdout, MtoRFSelWdout, DMoutWdout, ALUOutWdout, RFWAWdout,
    input  FwdRFWEM, FwdRFWAM, FwdALUOutM
  );

  modport slave (
    input  RFWEMdin, MtoRFSelMdin, DMWEMdin, DMdinMdin, ALUOutMdin, RFWAMdin, StallM, FlushM,
    output RFWEWdout, MtoRFSelWdout, DMoutWdout, ALUOutWdout, RFWAWdout,
    output FwdRFWEM, FwdRFWAM, FwdALUOutM
  );

endinterface

// File: rtl/memory_stage_data_mem.sv
// Word-addressed data memory: combinational read, synchronous write, contents never reset.
module data_mem #(
  parameter int DEPTH = 64,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= wdata;
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: data-memory access, MEM/WB register, forwarding taps,
// sticky address-fault flag and saturating load/store counters.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int DM_DEPTH = DM_DEPTH_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  memory_stage_if.slave    bus,
  output logic             MemErr,
  output logic [CNT_W-1:0] LoadCnt,
  output logic [CNT_W-1:0] StoreCnt
);

  localparam int IDX_W = dm_idx_w(DM_DEPTH);

  logic             is_load;
  logic             is_store;
  logic             fault;
  logic             dm_we;
  logic [IDX_W-1:0] word_idx;
  logic [31:0]      mem_rdata;
  logic [31:0]      read_data;

  logic             rfwe_q,      rfwe_d;
  logic             mtorf_q,     mtorf_d;
  logic [31:0]      dmout_q,     dmout_d;
  logic [31:0]      aluout_q,    aluout_d;
  logic [4:0]       rfwa_q,      rfwa_d;
  logic             mem_err_q,   mem_err_d;
  logic [CNT_W-1:0] load_cnt_q,  load_cnt_d;
  logic [CNT_W-1:0] store_cnt_q, store_cnt_d;

  // Reset is folded into the write enable so an edge with RST high never stores.
  always_comb begin
    is_load   = bus.MtoRFSelMdin & bus.RFWEMdin;
    is_store  = bus.DMWEMdin;
    fault     = (is_load | is_store) & addr_fault(bus.ALUOutMdin, IDX_W);
    word_idx  = bus.ALUOutMdin[IDX_W+1:2];
    dm_we     = is_store & ~fault & ~bus.StallM & ~RST;
    read_data = fault ? 32'd0 : mem_rdata;
  end

  data_mem #(
    .DEPTH (DM_DEPTH),
    .IDX_W (IDX_W)
  ) u_data_mem (
    .clk   (CLK),
    .we    (dm_we),
    .idx   (word_idx),
    .wdata (bus.DMdinMdin),
    .rdata (mem_rdata)
  );

  always_comb begin
    rfwe_d      = rfwe_q;
    mtorf_d     = mtorf_q;
    dmout_d     = dmout_q;
    aluout_d    = aluout_q;
    rfwa_d      = rfwa_q;
    mem_err_d   = mem_err_q;
    load_cnt_d  = load_cnt_q;
    store_cnt_d = store_cnt_q;
    // Stall wins over flush; flush only kills the control bits, data still loads.
    if (!bus.StallM) begin
      rfwe_d    = bus.RFWEMdin & ~(fault & is_load) & ~bus.FlushM;
      mtorf_d   = bus.MtoRFSelMdin & ~bus.FlushM;
      dmout_d   = read_data;
      aluout_d  = bus.ALUOutMdin;
      rfwa_d    = bus.RFWAMdin;
      mem_err_d = mem_err_q | fault;
      if (is_load && !fault && (load_cnt_q != {CNT_W{1'b1}})) begin
        load_cnt_d = load_cnt_q + CNT_W'(1);
      end
      if (is_store && !fault && (store_cnt_q != {CNT_W{1'b1}})) begin
        store_cnt_d = store_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rfwe_q      <= 1'b0;
      mtorf_q     <= 1'b0;
      dmout_q     <= 32'd0;
      aluout_q    <= 32'd0;
      rfwa_q      <= 5'd0;
      mem_err_q   <= 1'b0;
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else begin
      rfwe_q      <= rfwe_d;
      mtorf_q     <= mtorf_d;
      dmout_q     <= dmout_d;
      aluout_q    <= aluout_d;
      rfwa_q      <= rfwa_d;
      mem_err_q   <= mem_err_d;
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
    end
  end

  assign bus.RFWEWdout     = rfwe_q;
  assign bus.MtoRFSelWdout = mtorf_q;
  assign bus.DMoutWdout    = dmout_q;
  assign bus.ALUOutWdout   = aluout_q;
  assign bus.RFWAWdout     = rfwa_q;

  assign bus.FwdRFWEM   = bus.RFWEMdin;
  assign bus.FwdRFWAM   = bus.RFWAMdin;
  assign bus.FwdALUOutM = bus.ALUOutMdin;

  assign MemErr   = mem_err_q;
  assign LoadCnt  = load_cnt_q;
  assign StoreCnt = store_cnt_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage (DM_DEPTH=64, CNT_W=4): a vector table walked
// cycle by cycle, then hand sequences for async reset, faults and saturation.
module tb_memory_stage;

  logic       CLK;
  logic       RST;
  logic       mem_err;
  logic [3:0] load_cnt;
  logic [3:0] store_cnt;

  int test_count = 0;
  int fail_count = 0;

  memory_stage_if bus_if ();

  memory_stage #(
    .DM_DEPTH (64),
    .CNT_W    (4)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .bus      (bus_if),
    .MemErr   (mem_err),
    .LoadCnt  (load_cnt),
    .StoreCnt (store_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic        rfwe, mtorf, dmwe;
    logic [31:0] din, alu;
    logic [4:0]  rfwa;
    logic        stall, flush;
    logic        e_rfwe, e_mtorf, dm_chk;
    logic [31:0] e_dm, e_alu;
    logic [4:0]  e_rfwa;
    logic        e_err;
    logic [3:0]  e_lc, e_sc;
  } vec_t;

  vec_t vecs[$];
  logic prev_err;

  function automatic vec_t mk(
    logic rfwe, logic mtorf, logic dmwe, logic [31:0] din, logic [31:0] alu,
    logic [4:0] rfwa, logic stall, logic flush,
    logic e_rfwe, logic e_mtorf, logic dm_chk, logic [31:0] e_dm, logic [31:0] e_alu,
    logic [4:0] e_rfwa, logic e_err, logic [3:0] e_lc, logic [3:0] e_sc);
    vec_t v;
    v.rfwe = rfwe; v.mtorf = mtorf; v.dmwe = dmwe; v.din = din; v.alu = alu;
    v.rfwa = rfwa; v.stall = stall; v.flush = flush;
    v.e_rfwe = e_rfwe; v.e_mtorf = e_mtorf; v.dm_chk = dm_chk; v.e_dm = e_dm;
    v.e_alu = e_alu; v.e_rfwa = e_rfwa; v.e_err = e_err; v.e_lc = e_lc; v.e_sc = e_sc;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    test_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rfwe, input logic mtorf, input logic dmwe,
                       input logic [31:0] din, input logic [31:0] alu, input logic [4:0] rfwa,
                       input logic stall, input logic flush);
    bus_if.RFWEMdin     = rfwe;
    bus_if.MtoRFSelMdin = mtorf;
    bus_if.DMWEMdin     = dmwe;
    bus_if.DMdinMdin    = din;
    bus_if.ALUOutMdin   = alu;
    bus_if.RFWAMdin     = rfwa;
    bus_if.StallM       = stall;
    bus_if.FlushM       = flush;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rfwe"},  32'(bus_if.RFWEWdout), 32'd0);
    checkOutput({tag, "_mtorf"}, 32'(bus_if.MtoRFSelWdout), 32'd0);
    checkOutput({tag, "_dmout"}, bus_if.DMoutWdout, 32'd0);
    checkOutput({tag, "_alu"},   bus_if.ALUOutWdout, 32'd0);
    checkOutput({tag, "_rfwa"},  32'(bus_if.RFWAWdout), 32'd0);
    checkOutput({tag, "_err"},   32'(mem_err), 32'd0);
    checkOutput({tag, "_lc"},    32'(load_cnt), 32'd0);
    checkOutput({tag, "_sc"},    32'(store_cnt), 32'd0);
  endtask

  // Drive one vector, check forwarding and pre-edge MemErr, clock, check MEM/WB.
  task automatic applyStimulus(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    drive(v.rfwe, v.mtorf, v.dmwe, v.din, v.alu, v.rfwa, v.stall, v.flush);
    #1;
    checkOutput({tag, "_fwd_rfwe"}, 32'(bus_if.FwdRFWEM), 32'(v.rfwe));
    checkOutput({tag, "_fwd_rfwa"}, 32'(bus_if.FwdRFWAM), 32'(v.rfwa));
    checkOutput({tag, "_fwd_alu"},  bus_if.FwdALUOutM, v.alu);
    checkOutput({tag, "_pre_err"},  32'(mem_err), 32'(prev_err));
    @(posedge CLK);
    #1;
    checkOutput({tag, "_rfwe"},  32'(bus_if.RFWEWdout), 32'(v.e_rfwe));
    checkOutput({tag, "_mtorf"}, 32'(bus_if.MtoRFSelWdout), 32'(v.e_mtorf));
    if (v.dm_chk) checkOutput({tag, "_dmout"}, bus_if.DMoutWdout, v.e_dm);
    checkOutput({tag, "_alu"},   bus_if.ALUOutWdout, v.e_alu);
    checkOutput({tag, "_rfwa"},  32'(bus_if.RFWAWdout), 32'(v.e_rfwa));
    checkOutput({tag, "_err"},   32'(mem_err), 32'(v.e_err));
    checkOutput({tag, "_lc"},    32'(load_cnt), 32'(v.e_lc));
    checkOutput({tag, "_sc"},    32'(store_cnt), 32'(v.e_sc));
    prev_err = v.e_err;
  endtask

  initial begin
    // rfwe mtorf dmwe din alu rfwa stall flush | e_rfwe e_mtorf dm_chk e_dm e_alu e_rfwa e_err e_lc e_sc
    vecs.push_back(mk(1,0,1,32'hDEADBEEF,32'h10,0,0,0, 0,0,0,32'h0,32'h10,0,0,0,1));
    vecs[0].rfwe = 1'b0;
    vecs.push_back(mk(1,1,0,32'h0,32'h10,5,0,0, 1,1,1,32'hDEADBEEF,32'h10,5,0,1,1));
    vecs.push_back(mk(0,0,1,32'h12345678,32'h20,0,0,0, 0,0,0,32'h0,32'h20,0,0,1,2));
    vecs.push_back(mk(1,1,0,32'h0,32'h20,7,0,0, 1,1,1,32'h12345678,32'h20,7,0,2,2));
    vecs.push_back(mk(1,0,0,32'h0,32'hCAFEF00D,3,0,0, 1,0,0,32'h0,32'hCAFEF00D,3,0,2,2));
    vecs.push_back(mk(0,0,1,32'h0BADF00D,32'h20,0,1,0, 1,0,0,32'h0,32'hCAFEF00D,3,0,2,2));
    vecs.push_back(mk(1,1,0,32'h0,32'h20,9,0,0, 1,1,1,32'h12345678,32'h20,9,0,3,2));
    vecs.push_back(mk(1,0,0,32'h0,32'h10,4,0,1, 0,0,1,32'hDEADBEEF,32'h10,4,0,3,2));
    vecs.push_back(mk(1,1,0,32'h0,32'h20,2,1,1, 0,0,1,32'hDEADBEEF,32'h10,4,0,3,2));
    vecs.push_back(mk(1,1,1,32'h11111111,32'h10,6,0,0, 1,1,1,32'hDEADBEEF,32'h10,6,0,4,3));
    vecs.push_back(mk(1,1,0,32'h0,32'h10,6,0,0, 1,1,1,32'h11111111,32'h10,6,0,5,3));
    vecs.push_back(mk(0,0,1,32'hFFFFFFFF,32'h12,0,0,0, 0,0,0,32'h0,32'h12,0,1,5,3));
    vecs.push_back(mk(1,1,0,32'h0,32'h10,1,0,0, 1,1,1,32'h11111111,32'h10,1,1,6,3));
    vecs.push_back(mk(1,1,0,32'h0,32'h400,8,0,0, 0,1,1,32'h0,32'h400,8,1,6,3));

    RST = 1'b1;
    drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 0);
    prev_err = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checkAllZero("reset");
    RST = 1'b0;

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // Async reset during a store to 0x20: outputs clear at once, the write is blocked.
    drive(0, 0, 1, 32'h55555555, 32'h20, 5'd0, 0, 0);
    #2 RST = 1'b1;
    #1 checkAllZero("rst_mid");
    @(posedge CLK);
    #1 RST = 1'b0;
    drive(1, 1, 0, 32'h0, 32'h20, 5'd1, 0, 0);
    @(posedge CLK);
    #1;
    checkOutput("rst_keep_dm", bus_if.DMoutWdout, 32'h12345678);
    checkOutput("rst_keep_rfwe", 32'(bus_if.RFWEWdout), 32'd1);
    checkOutput("rst_keep_lc", 32'(load_cnt), 32'd1);

    // First fault after reset: MemErr rises only from the edge.
    drive(1, 1, 0, 32'h0, 32'h400, 5'd8, 0, 0);
    #1 checkOutput("oob_pre_err", 32'(mem_err), 32'd0);
    @(posedge CLK);
    #1;
    checkOutput("oob_err", 32'(mem_err), 32'd1);
    checkOutput("oob_dmout", bus_if.DMoutWdout, 32'd0);
    checkOutput("oob_rfwe", 32'(bus_if.RFWEWdout), 32'd0);
    checkOutput("oob_lc", 32'(load_cnt), 32'd1);

    // 20 loads saturate the 4-bit counter without wrapping.
    drive(1, 1, 0, 32'h0, 32'h10, 5'd2, 0, 0);
    for (int k = 0; k < 20; k++) begin
      @(posedge CLK);
      #1;
      if (k == 13) checkOutput("sat_lc_at15", 32'(load_cnt), 32'hF);
    end
    checkOutput("sat_lc", 32'(load_cnt), 32'hF);
    checkOutput("sat_sc", 32'(store_cnt), 32'd0);
    checkOutput("sat_dm", bus_if.DMoutWdout, 32'h11111111);

    // Reset mid-run, then earlier memory contents are still readable.
    #2 RST = 1'b1;
    #1 checkAllZero("rst2");
    @(posedge CLK);
    #1 RST = 1'b0;
    drive(1, 1, 0, 32'h0, 32'h10, 5'd3, 0, 0);
    @(posedge CLK);
    #1;
    checkOutput("rst2_dm", bus_if.DMoutWdout, 32'h11111111);
    checkOutput("rst2_lc", 32'(load_cnt), 32'd1);
    checkOutput("rst2_err", 32'(mem_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
